// File: rtl/ising_run_ctrl.sv
// Run sequencer for the shorted-RO Ising array: short, anneal, majority-vote
// sample of each spin against the reference oscillator, then hand the result to the host.
module ising_run_ctrl #(
  parameter int N          = 8,
  parameter int CNT_W      = 16,
  parameter int SHORT_CYC  = 4,
  parameter int SAMPLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             abort,
  output logic             osc_en,
  output logic             short_en,
  input  logic [N-1:0]     spin_in,
  input  logic             ref_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [N-1:0]     spins
);

  localparam int SC_W    = $clog2(SAMPLE_CYC + 1);
  localparam int PH_MAX  = (SHORT_CYC > SAMPLE_CYC) ? SHORT_CYC : SAMPLE_CYC;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SHORT_LAST  = PH_W'(SHORT_CYC - 1);
  localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(SAMPLE_CYC - 1);
  localparam logic [SC_W-1:0] VOTE_HALF   = SC_W'(SAMPLE_CYC / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHORT,
    ST_ANNEAL,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] anneal_q, anneal_d;
  logic [N-1:0]     spins_q, spins_d;
  logic [SC_W-1:0]  vote_q [N];
  logic [SC_W-1:0]  vote_d [N];
  logic [SC_W-1:0]  vote_inc [N];
  logic [N-1:0]     spin_s1_q, spin_s1_d, spin_s2_q, spin_s2_d;
  logic             ref_s1_q, ref_s1_d, ref_s2_q, ref_s2_d;

  // Vote count including the current cycle's phase disagreement.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      vote_inc[i] = vote_q[i] + SC_W'(spin_s2_q[i] ^ ref_s2_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    anneal_d  = anneal_q;
    spins_d   = spins_q;
    vote_d    = vote_q;
    spin_s1_d = spin_in;
    spin_s2_d = spin_s1_q;
    ref_s1_d  = ref_in;
    ref_s2_d  = ref_s1_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d  = ST_SHORT;
          anneal_d = run_cycles;
          phase_d  = '0;
        end
      end
      ST_SHORT: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (phase_q == SHORT_LAST) begin
          phase_d = '0;
          vote_d  = '{default: '0};
          state_d = (anneal_q != '0) ? ST_ANNEAL : ST_SAMPLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_ANNEAL: begin
        anneal_d = anneal_q - CNT_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (anneal_q == CNT_W'(1)) begin
          phase_d = '0;
          vote_d  = '{default: '0};
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          vote_d = vote_inc;
          if (phase_q == SAMPLE_LAST) begin
            // A tie on even SAMPLE_CYC resolves to 0 because the compare is strict.
            for (int i = 0; i < N; i++) begin
              spins_d[i] = (vote_inc[i] > VOTE_HALF);
            end
            phase_d = '0;
            state_d = ST_HOLD;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      anneal_q  <= '0;
      spins_q   <= '0;
      spin_s1_q <= '0;
      spin_s2_q <= '0;
      ref_s1_q  <= 1'b0;
      ref_s2_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vote_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      anneal_q  <= anneal_d;
      spins_q   <= spins_d;
      spin_s1_q <= spin_s1_d;
      spin_s2_q <= spin_s2_d;
      ref_s1_q  <= ref_s1_d;
      ref_s2_q  <= ref_s2_d;
      for (int i = 0; i < N; i++) begin
        vote_q[i] <= vote_d[i];
      end
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign osc_en       = (state_q == ST_SHORT) || (state_q == ST_ANNEAL) || (state_q == ST_SAMPLE);
  assign short_en     = (state_q == ST_SHORT);
  assign result_valid = (state_q == ST_HOLD);
  assign spins        = spins_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Self-checking bench for ising_run_ctrl: vector table, hand-written abort/reset
// sequences and randomized runs checked against a timeline/majority-vote model.
module tb_ising_run_ctrl;

  localparam int N          = 4;
  localparam int CNT_W      = 16;
  localparam int SHORT_CYC  = 4;
  localparam int SAMPLE_CYC = 8;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [CNT_W-1:0] run_cycles;
  logic             abort;
  logic             osc_en;
  logic             short_en;
  logic [N-1:0]     spin_in;
  logic             ref_in;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [N-1:0]     spins;

  ising_run_ctrl #(
    .N(N), .CNT_W(CNT_W), .SHORT_CYC(SHORT_CYC), .SAMPLE_CYC(SAMPLE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .run_cycles(run_cycles),
    .abort(abort), .osc_en(osc_en), .short_en(short_en),
    .spin_in(spin_in), .ref_in(ref_in), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .spins(spins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [N-1:0] spin_hist [int];
  logic         ref_hist  [int];
  logic [N-1:0] prev_spins;

  typedef struct {
    logic [CNT_W-1:0] r;
    int               mode;
    logic [N-1:0]     sp;
    logic             rf;
    int               k;
    int               lat;
    int               rw;
    logic [N-1:0]     exp_sp;
  } vec_t;

  vec_t vecs [6];

  // Outputs are observed 1 time unit after the active edge; cyc names the cycle just begun.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input bit e_osc, input bit e_short, input bit e_busy,
                          input bit e_rv, input bit e_sr, input logic [N-1:0] e_sp);
    checkOutput({tag, " osc_en"},       8'(osc_en),       8'(e_osc));
    checkOutput({tag, " short_en"},     8'(short_en),     8'(e_short));
    checkOutput({tag, " busy"},         8'(busy),         8'(e_busy));
    checkOutput({tag, " result_valid"}, 8'(result_valid), 8'(e_rv));
    checkOutput({tag, " start_ready"},  8'(start_ready),  8'(e_sr));
    checkOutput({tag, " spins"},        8'(spins),        8'(e_sp));
  endtask

  // mode 0: static pattern; mode 1: random per cycle; mode 2: spin[0] high for k cycles from base.
  task automatic applyStimulus(input int mode, input logic [N-1:0] sp, input logic rf,
                               input int k, input int base);
    case (mode)
      0: begin spin_in = sp; ref_in = rf; end
      1: begin spin_in = N'($urandom); ref_in = 1'($urandom); end
      default: begin
        spin_in = (cyc >= base && cyc < base + k) ? N'(1) : N'(0);
        ref_in  = 1'b0;
      end
    endcase
    spin_hist[cyc] = spin_in;
    ref_hist[cyc]  = ref_in;
  endtask

  // One full run started in the current IDLE cycle. The model expects HOLD from T+lat,
  // consumes the result rw cycles later, and derives spins by majority over the sample window.
  task automatic runOne(input string tag, input logic [CNT_W-1:0] r, input int mode,
                        input logic [N-1:0] sp, input logic rf, input int k, input int lat,
                        input int rw, input bit use_exp, input logic [N-1:0] exp_sp);
    int T, hs, he, cnt;
    logic [N-1:0] model_sp;
    T  = cyc;
    hs = T + lat;
    he = hs + rw;
    start_valid  = 1'b1;
    run_cycles   = r;
    abort        = 1'b1;
    result_ready = 1'b0;
    applyStimulus(mode, sp, rf, k, T + 3 + int'(r));
    checkOutput({tag, " start_ready at start"}, 8'(start_ready), 8'd1);
    tick();
    run_cycles = CNT_W'($urandom);
    for (int t = T + 1; t <= he + 1; t++) begin
      abort        = (t >= hs && t <= he);
      start_valid  = (t <= he) ? 1'($urandom_range(0, 1)) : 1'b0;
      result_ready = (t == he) ? 1'b1 : ((t < hs) ? 1'($urandom_range(0, 1)) : 1'b0);
      applyStimulus(mode, sp, rf, k, T + 3 + int'(r));
      if (t == hs) begin
        for (int i = 0; i < N; i++) begin
          cnt = 0;
          for (int c = hs - SAMPLE_CYC; c < hs; c++) begin
            if (spin_hist[c-2][i] != ref_hist[c-2]) cnt++;
          end
          model_sp[i] = (cnt > SAMPLE_CYC / 2);
        end
        prev_spins = use_exp ? exp_sp : model_sp;
      end
      checkAll(tag, (t < hs), (t <= T + SHORT_CYC), (t <= he), (t >= hs && t <= he),
               (t > he), prev_spins);
      tick();
    end
    start_valid  = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'd10, 0, 4'b0101, 1'b0, 0, 23, 2,  4'b0101};
    vecs[1] = '{16'd0,  0, 4'b1100, 1'b1, 0, 13, 0,  4'b0011};
    vecs[2] = '{16'd3,  0, 4'b1111, 1'b0, 0, 16, 1,  4'b1111};
    vecs[3] = '{16'd0,  2, 4'b0000, 1'b0, 4, 13, 0,  4'b0000};
    vecs[4] = '{16'd0,  2, 4'b0000, 1'b0, 5, 13, 0,  4'b0001};
    vecs[5] = '{16'd2,  0, 4'b0000, 1'b1, 0, 15, 20, 4'b1111};

    rst = 1'b1; start_valid = 1'b0; run_cycles = '0; abort = 1'b0;
    spin_in = '0; ref_in = 1'b0; result_ready = 1'b0;
    prev_spins = '0;

    // Reset held for three cycles, with a start request that must be ignored.
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkAll("reset held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    start_valid = 1'b0;
    rst = 1'b0;
    tick();
    checkAll("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

    for (int i = 0; i < 6; i++) begin
      runOne($sformatf("vec%0d", i), vecs[i].r, vecs[i].mode, vecs[i].sp, vecs[i].rf,
             vecs[i].k, vecs[i].lat, vecs[i].rw, 1'b1, vecs[i].exp_sp);
      tick();
    end

    // Abort on the third ANNEAL cycle: back to IDLE, previous spins retained.
    begin
      int T;
      T = cyc;
      spin_in = 4'b0000; ref_in = 1'b0;
      start_valid = 1'b1; run_cycles = 16'd10;
      tick();
      start_valid = 1'b0;
      while (cyc < T + 7) tick();
      checkAll("abort pre", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, prev_spins);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkAll("abort post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev_spins);
      for (int i = 0; i < 15; i++) begin
        tick();
        checkOutput("abort no result", 8'(result_valid), 8'd0);
      end
    end

    // Reset during SAMPLE: everything back to reset values including spins.
    begin
      int T;
      T = cyc;
      spin_in = 4'b1111; ref_in = 1'b0;
      start_valid = 1'b1; run_cycles = 16'd0;
      tick();
      start_valid = 1'b0;
      while (cyc < T + 7) tick();
      checkAll("rst pre", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, prev_spins);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prev_spins = '0;
      checkAll("rst post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 15; i++) begin
        tick();
        checkOutput("rst no result", 8'(result_valid), 8'd0);
      end
    end

    // Randomized runs against the model.
    for (int i = 0; i < 20; i++) begin
      int r;
      r = $urandom_range(0, 6);
      runOne($sformatf("rand%0d", i), CNT_W'(r), 1, 4'b0000, 1'b0, 0, 13 + r,
             $urandom_range(0, 3), 1'b0, 4'b0000);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
